// File: rtl/ex_muldiv_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_ctrl_if
// Brief    : EX-stage multiply/divide sequencer operand/result bundle.
// Revision : 1.0
// ============================================================================
interface ex_muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, A, B, flush,
        input  stall, busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, A, B, flush,
        output stall, busy, done, div_by_zero, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_ctrl
// Brief    : Iterative shift-add multiply / restoring divide into HI/LO.
//            Optional MULDIV_SIGNED_EN adds signed MULT/DIV via op[1].
// Revision : 1.0
// ============================================================================
module ex_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    ex_muldiv_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CW-1:0]       r_cnt;
    logic                r_is_div;
    logic                r_dbz;
    logic [WIDTH-1:0]    r_opb;
    logic [2*WIDTH-1:0]  r_acc;
    logic [WIDTH:0]      r_rem;
    logic [WIDTH-1:0]    r_quo;
    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;

    logic                w_launch;
    logic                w_b_zero;
    logic                w_stall;
    logic                w_busy;
    logic                w_done;
    logic [WIDTH-1:0]    w_a_mag;
    logic [WIDTH-1:0]    w_b_mag;
    logic [WIDTH:0]      w_add;
    logic [WIDTH+1:0]    w_shift;
    logic [WIDTH+1:0]    w_diff;
    logic [2*WIDTH-1:0]  w_prod;
    logic [WIDTH-1:0]    w_quo;
    logic [WIDTH-1:0]    w_rem;

    assign w_launch = (r_state == S_IDLE) && bus.start && !bus.flush;
    assign w_b_zero = (bus.B == '0);

`ifdef MULDIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;
    logic w_a_neg;
    logic w_b_neg;

    assign w_a_neg = bus.op[1] & bus.A[WIDTH-1];
    assign w_b_neg = bus.op[1] & bus.B[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~bus.A + 1'b1) : bus.A;
    assign w_b_mag = w_b_neg ? (~bus.B + 1'b1) : bus.B;
`else
    logic w_unused_op1;

    assign w_unused_op1 = bus.op[1];
    assign w_a_mag      = bus.A;
    assign w_b_mag      = bus.B;
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        w_busy  = (r_state != S_IDLE);
        w_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = w_launch;
                if (w_launch) begin
                    w_next = (bus.op[0] && w_b_zero) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_stall = 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done = !bus.flush;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (bus.flush) begin
            w_next = S_IDLE;
        end
    end

    // ----------------------------------------------------------- datapath
    // Multiply: add multiplicand into the upper half on LSB=1, then shift right.
    assign w_add = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);

    // Divide: remainder is always below the divisor, so the top bit is the borrow.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {2'b00, r_opb};

    always_comb begin
        w_prod = r_acc;
        w_quo  = r_quo;
        w_rem  = r_rem[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
        if (r_neg_q) begin
            w_prod = ~r_acc + 1'b1;
            w_quo  = ~r_quo + 1'b1;
        end
        if (r_neg_r) begin
            w_rem = ~r_rem[WIDTH-1:0] + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_dbz    <= 1'b0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
`ifdef MULDIV_SIGNED_EN
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
`endif
        end else begin
            if (w_launch) begin
                r_cnt    <= CW'(WIDTH);
                r_is_div <= bus.op[0];
                r_dbz    <= bus.op[0] && w_b_zero;
                r_opb    <= bus.op[0] ? w_b_mag : w_a_mag;
                r_acc    <= {{WIDTH{1'b0}}, w_b_mag};
                r_rem    <= '0;
                // Divide-by-zero keeps the raw dividend for HI.
                r_quo    <= (bus.op[0] && w_b_zero) ? bus.A : w_a_mag;
`ifdef MULDIV_SIGNED_EN
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
`endif
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt - 1'b1;
                if (r_is_div) begin
                    if (w_diff[WIDTH+1]) begin
                        r_rem <= w_shift[WIDTH:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end else begin
                        r_rem <= w_diff[WIDTH:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end
                end else begin
                    r_acc <= {w_add, r_acc[WIDTH-1:1]};
                end
            end

            if ((r_state == S_DONE) && !bus.flush) begin
                if (r_dbz) begin
                    r_hi <= r_quo;
                    r_lo <= '1;
                end else if (r_is_div) begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end else begin
                    r_hi <= w_prod[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod[WIDTH-1:0];
                end
            end
        end
    end

    assign bus.stall       = w_stall;
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.div_by_zero = w_done && r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv_ctrl
// Brief    : Self-checking bench for ex_muldiv_ctrl (cycle-level reference model).
// Revision : 1.0
// ============================================================================
module tb_ex_muldiv_ctrl;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ex_muldiv_ctrl_if #(.WIDTH(W)) bus ();
    ex_muldiv_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int n_chk    = 0;
    int n_err    = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, straight from arithmetic.
    function automatic void calc(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
        logic [63:0] p;
`ifdef MULDIV_SIGNED_EN
        longint sa, sb, q, r;
`endif
        dz = 1'b0;
        if (op[0] && b == 0) begin
            hi = a; lo = '1; dz = 1'b1;
        end
`ifdef MULDIV_SIGNED_EN
        else if (op[1]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            if (!op[0]) begin
                p = 64'(sa * sb);
                hi = p[63:32]; lo = p[31:0];
            end else begin
                q = sa / sb; r = sa % sb;
                hi = r[31:0]; lo = q[31:0];
            end
        end
`endif
        else if (!op[0]) begin
            p = {32'b0, a} * {32'b0, b};
            hi = p[63:32]; lo = p[31:0];
        end else begin
            hi = a % b; lo = a / b;
        end
    endfunction

    // Reference model: tracks the in-flight op by the cycle its result is due.
    logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
    logic         m_busy, p_dz, was_busy;
    int           n, m_done_at;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 1'b0; m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; p_dz = 1'b0;
            n = 0; m_done_at = 0;
        end else begin
            n++;
            was_busy = m_busy;
            if (m_busy && !bus.flush && (n - 1 == m_done_at)) begin
                m_hi = p_hi; m_lo = p_lo; m_busy = 1'b0;
            end
            if (bus.flush) m_busy = 1'b0;
            if (!was_busy && bus.start && !bus.flush) begin
                calc(bus.op, bus.A, bus.B, p_hi, p_lo, p_dz);
                m_busy = 1'b1;
                m_done_at = n + (p_dz ? 0 : W);
            end
        end
    end

    logic e_done, e_stall;
    always @(negedge clk) begin
        e_done  = m_busy && (n == m_done_at) && !bus.flush;
        e_stall = (m_busy && (n < m_done_at)) || (!m_busy && bus.start && !bus.flush);
        chk("busy",  64'(bus.busy),        64'(m_busy));
        chk("stall", 64'(bus.stall),       64'(e_stall));
        chk("done",  64'(bus.done),        64'(e_done));
        chk("dbz",   64'(bus.div_by_zero), 64'(e_done && p_dz));
        chk("hi",    64'(bus.hi),          64'(m_hi));
        chk("lo",    64'(bus.lo),          64'(m_lo));
        if (bus.done) done_cnt++;
    end

    // Caller is positioned just after a rising edge; returns at the done sample.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic dz);
        logic got;
        bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
        @(posedge clk); #2 bus.start = 1'b0;
        lat = 0; dz = 1'b0; got = 1'b0;
        while (!got && lat <= 200) begin
            @(negedge clk);
            if (bus.done) begin
                dz = bus.div_by_zero; got = 1'b1;
            end else begin
                lat++;
            end
        end
        if (!got) begin
            n_chk++; n_err++;
            $display("FAIL run_op_timeout: no done after %0d cycles, required a done pulse", lat);
        end
    endtask

    logic [W-1:0] h, l;
    logic         z;
    int           lat, d0;

    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.A = '0; bus.B = '0; bus.flush = 1'b0;

        calc(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l, z);
        chk("model_mul", {h, l}, 64'hFFFF_FFFE_0000_0001);
        calc(2'b01, 32'd100, 32'd7, h, l, z);
        chk("model_div", {h, l}, {32'd2, 32'd14});

        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #2;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_hi",   64'(bus.hi),   64'd0);
        chk("rst_lo",   64'(bus.lo),   64'd0);

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, z);
        chk("mul_lat", 64'(lat), 64'd32);
        @(posedge clk); #2;
        chk("mul_hi", 64'(bus.hi), 64'hFFFF_FFFE);
        chk("mul_lo", 64'(bus.lo), 64'h0000_0001);

        run_op(2'b01, 32'd5, 32'd0, lat, z);
        chk("dz_lat", 64'(lat), 64'd0);
        chk("dz_flag", 64'(z), 64'd1);
        @(posedge clk); #2;
        chk("dz_hi", 64'(bus.hi), 64'd5);
        chk("dz_lo", 64'(bus.lo), 64'hFFFF_FFFF);

        run_op(2'b01, 32'd100, 32'd7, lat, z);
        chk("div_lat", 64'(lat), 64'd32);
        chk("div_flag", 64'(z), 64'd0);
        @(posedge clk); #2;
        chk("div_hi", 64'(bus.hi), 64'd2);
        chk("div_lo", 64'(bus.lo), 64'd14);

        // Flush mid-multiply, with an ignored re-start while busy.
        d0 = done_cnt;
        bus.start = 1'b1; bus.op = 2'b00; bus.A = 32'd3; bus.B = 32'd4;
        @(posedge clk); #2 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 bus.start = 1'b1; bus.op = 2'b01; bus.A = 32'd50; bus.B = 32'd5;
        @(posedge clk); #2 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 bus.flush = 1'b1;
        @(posedge clk); #2 bus.flush = 1'b0;
        chk("flush_busy", 64'(bus.busy), 64'd0);
        repeat (40) @(posedge clk);
        #2;
        chk("flush_nodone", 64'(done_cnt - d0), 64'd0);
        chk("flush_hi", 64'(bus.hi), 64'd2);
        chk("flush_lo", 64'(bus.lo), 64'd14);

        // Back-to-back issue in the cycle after done.
        d0 = done_cnt;
        run_op(2'b00, 32'd3, 32'd4, lat, z);
        @(posedge clk); #2;
        chk("b2b_lo1", 64'(bus.lo), 64'd12);
        run_op(2'b01, 32'd9, 32'd2, lat, z);
        @(posedge clk); #2;
        chk("b2b_lo2", 64'(bus.lo), 64'd4);
        chk("b2b_hi2", 64'(bus.hi), 64'd1);
        chk("b2b_pulses", 64'(done_cnt - d0), 64'd2);

`ifdef MULDIV_SIGNED_EN
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat, z);
        @(posedge clk); #2;
        chk("sdiv_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        chk("sdiv_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        run_op(2'b10, 32'hFFFF_FFFD, 32'd5, lat, z);
        @(posedge clk); #2;
        chk("smul_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        chk("smul_lo", 64'(bus.lo), 64'hFFFF_FFF1);
`endif

        // Asynchronous reset in the middle of a multiply.
        bus.start = 1'b1; bus.op = 2'b00; bus.A = 32'd7; bus.B = 32'd9;
        @(posedge clk); #2 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("arst_busy",  64'(bus.busy),  64'd0);
        chk("arst_stall", 64'(bus.stall), 64'd0);
        chk("arst_hi",    64'(bus.hi),    64'd0);
        chk("arst_lo",    64'(bus.lo),    64'd0);
        @(posedge clk); #2 reset = 1'b1;
        d0 = done_cnt;
        repeat (40) @(posedge clk);
        #2;
        chk("arst_nodone", 64'(done_cnt - d0), 64'd0);

        // Randomized traffic; the per-cycle compare process does the checking.
        for (int i = 0; i < 3000; i++) begin
            bus.start = ($urandom_range(0, 3) == 0);
            bus.flush = ($urandom_range(0, 79) == 0);
            bus.op    = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       begin bus.A = $urandom; bus.B = '0; end
                1, 2:    begin bus.A = 32'($urandom_range(0, 255)); bus.B = 32'($urandom_range(1, 15)); end
                3:       begin bus.A = 32'hFFFF_FFFF - 32'($urandom_range(0, 8)); bus.B = $urandom; end
                default: begin bus.A = $urandom; bus.B = $urandom; end
            endcase
            @(posedge clk); #2;
        end
        bus.start = 1'b0; bus.flush = 1'b0;
        repeat (40) @(posedge clk);
        #2;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
